// File: rtl/logic_unit_pipe.sv
// Registered 8-op bitwise logic unit with valid/ready handshake, main+skid output buffer
// and transfer counter. Define LOGIC_UNIT_FLAGS_EN to add the flag_z/flag_p outputs.
module logic_unit_pipe #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ina,
   input  logic [WIDTH-1:0] inb,
   input  logic [2:0]       op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [CNT_W-1:0] op_count
`ifdef LOGIC_UNIT_FLAGS_EN
   ,
   output logic             flag_z,
   output logic             flag_p
`endif
);

   typedef enum logic [2:0] {
      OP_AND  = 3'b000,
      OP_OR   = 3'b001,
      OP_XOR  = 3'b010,
      OP_NOR  = 3'b011,
      OP_NAND = 3'b100,
      OP_XNOR = 3'b101,
      OP_NOTA = 3'b110,
      OP_PASS = 3'b111
   } op_e;

   // Flags travel in the upper payload bits so they are buffered exactly like the result.
`ifdef LOGIC_UNIT_FLAGS_EN
   localparam int unsigned PW = WIDTH + 2;
`else
   localparam int unsigned PW = WIDTH;
`endif

   logic [WIDTH-1:0] res;
   logic [PW-1:0]    res_pl;
   op_e              op_sel;

   logic [PW-1:0]    main_q, main_d;
   logic             main_valid_q, main_valid_d;
   logic [PW-1:0]    skid_q, skid_d;
   logic             skid_valid_q, skid_valid_d;
   logic             in_ready_q, in_ready_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic             accept;
   logic             load_main;
   logic             out_xfer;

   always_comb begin
      op_sel = op_e'(op);
      res    = '0;
      case (op_sel)
         OP_AND:  res = ina & inb;
         OP_OR:   res = ina | inb;
         OP_XOR:  res = ina ^ inb;
         OP_NOR:  res = ~(ina | inb);
         OP_NAND: res = ~(ina & inb);
         OP_XNOR: res = ~(ina ^ inb);
         OP_NOTA: res = ~ina;
         OP_PASS: res = ina;
         default: res = '0;
      endcase
   end

`ifdef LOGIC_UNIT_FLAGS_EN
   assign res_pl = {(res == '0), ^res, res};
`else
   assign res_pl = res;
`endif

   assign accept    = in_valid & in_ready_q;
   assign load_main = ~main_valid_q | out_ready;
   assign out_xfer  = main_valid_q & out_ready;

   always_comb begin
      main_d       = main_q;
      main_valid_d = main_valid_q;
      skid_d       = skid_q;
      skid_valid_d = skid_valid_q;

      if (load_main) begin
         if (skid_valid_q) begin
            main_d       = skid_q;
            main_valid_d = 1'b1;
            // Skid drains into main; a same-cycle accept takes its place behind it.
            skid_valid_d = accept;
            if (accept) begin
               skid_d = res_pl;
            end
         end else begin
            main_valid_d = accept;
            if (accept) begin
               main_d = res_pl;
            end
         end
      end else if (accept) begin
         skid_d       = res_pl;
         skid_valid_d = 1'b1;
      end

      in_ready_d = ~skid_valid_d;
   end

   always_comb begin
      cnt_d = cnt_q;
      if (out_xfer) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_q       <= '0;
         main_valid_q <= 1'b0;
         skid_q       <= '0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
         cnt_q        <= '0;
      end else begin
         main_q       <= main_d;
         main_valid_q <= main_valid_d;
         skid_q       <= skid_d;
         skid_valid_q <= skid_valid_d;
         in_ready_q   <= in_ready_d;
         cnt_q        <= cnt_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign out       = main_q[WIDTH-1:0];
   assign op_count  = cnt_q;

`ifdef LOGIC_UNIT_FLAGS_EN
   assign flag_z = main_q[WIDTH+1];
   assign flag_p = main_q[WIDTH];
`endif

endmodule
